// File: rtl/ddc_pkg.sv
// ddc_pkg: shared constants, FSM state codes and channel-count clamp for the DDC sequencer
package ddc_pkg;
  localparam int N_CH_MAX = 128;
  localparam int CH_IDX_W = $clog2(N_CH_MAX);
  localparam int SAMPLE_W = 32;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN = 1'b1;
  function automatic logic [7:0] clamp_n_ch(input logic [7:0] n, input int unsigned max_ch);
    return (n == 8'd0) ? 8'd1 : (32'(n) > max_ch) ? 8'(max_ch) : n;
  endfunction
endpackage

// File: rtl/ddc_delay_line.sv
// ddc_delay_line: fixed-depth shift register with asynchronous active-low clear
module ddc_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] sr [DEPTH];
  // shift every cycle; reset empties the whole line so no stale entries emerge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  assign q = sr[DEPTH-1];
endmodule

// File: rtl/ddc_channel_sequencer.sv
// ddc_channel_sequencer: per-sample channel read bursts for the two-stage DDC tables
module ddc_channel_sequencer
  import ddc_pkg::*;
#(
  parameter int N_CH_MAX     = ddc_pkg::N_CH_MAX,
  parameter int SECOND_DELAY = 4
) (
  input  logic                        dev_clk,
  input  logic                        dev_aresetn,
  input  logic [SAMPLE_W-1:0]         data_in,
  input  logic                        valid_in,
  input  logic [7:0]                  cfg_n_ch,
  input  logic                        cfg_bypass_second,
  input  logic                        cfg_update,
  input  logic                        clr_overrun,
  output logic [SAMPLE_W-1:0]         sample_out,
  output logic                        rd_en_first,
  output logic [$clog2(N_CH_MAX)-1:0] index_first,
  output logic                        rd_en_second,
  output logic [$clog2(N_CH_MAX)-1:0] index_second,
  output logic                        bypass_second,
  output logic                        slot_last,
  output logic                        busy,
  output logic                        overrun
);
  localparam int IW = $clog2(N_CH_MAX);
  logic [0:0]          state;
  logic [IW-1:0]       cnt;
  logic [7:0]          n_ch;
  logic                pend_valid, upd_pend, slot_bypass;
  logic [SAMPLE_W-1:0] pend_data;
  logic                last, load_cfg, drop;
  logic [IW+1:0]       dl_q;
  assign last     = state == RUN && 8'(cnt) == n_ch - 8'd1;
  assign load_cfg = (cfg_update && state == IDLE) || ((upd_pend || cfg_update) && last);
  assign drop     = valid_in && pend_valid && state == RUN && !last;
  // burst FSM, one-deep sample buffer and burst-boundary config load
  always_ff @(posedge dev_clk or negedge dev_aresetn)
    if (!dev_aresetn) begin
      state         <= IDLE;
      cnt           <= '0;
      n_ch          <= 8'(N_CH_MAX);
      bypass_second <= 1'b0;
      pend_valid    <= 1'b0;
      pend_data     <= '0;
      upd_pend      <= 1'b0;
      slot_bypass   <= 1'b0;
      sample_out    <= '0;
      rd_en_first   <= 1'b0;
      index_first   <= '0;
      slot_last     <= 1'b0;
      busy          <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      rd_en_first <= state == RUN;
      busy        <= state == RUN;
      index_first <= cnt;
      slot_last   <= last;
      slot_bypass <= bypass_second;
      overrun     <= drop | (overrun & ~clr_overrun);
      upd_pend    <= !load_cfg && (upd_pend || cfg_update);
      if (load_cfg) begin
        n_ch          <= clamp_n_ch(cfg_n_ch, N_CH_MAX);
        bypass_second <= cfg_bypass_second;
      end
      if (state == IDLE) begin
        if (valid_in) begin
          sample_out <= data_in;
          state      <= RUN;
        end
      end else if (!last) begin
        cnt <= cnt + 1'b1;
        if (valid_in && !pend_valid) begin
          pend_data  <= data_in;
          pend_valid <= 1'b1;
        end
      end else begin
        cnt <= '0;
        if (pend_valid) begin
          sample_out <= pend_data;
          pend_data  <= data_in;
          pend_valid <= valid_in;
        end else if (valid_in) sample_out <= data_in;
        else state <= IDLE;
      end
    end
  ddc_delay_line #(.WIDTH(IW + 2), .DEPTH(SECOND_DELAY)) u_delay (
    .clk  (dev_clk),
    .rst_n(dev_aresetn),
    .d    ({slot_bypass, rd_en_first, index_first}),
    .q    (dl_q)
  );
  assign rd_en_second = dl_q[IW] & ~dl_q[IW+1];
  assign index_second = dl_q[IW-1:0];
endmodule

// File: tb/tb_ddc_channel_sequencer.sv
// tb_ddc_channel_sequencer: directed table-driven bench for the DDC channel sequencer
module tb_ddc_channel_sequencer;
  logic        dev_clk = 1'b0, dev_aresetn = 1'b0;
  logic [31:0] data_in = '0;
  logic        valid_in = 1'b0, cfg_bypass_second = 1'b0, cfg_update = 1'b0, clr_overrun = 1'b0;
  logic [7:0]  cfg_n_ch = '0;
  logic [31:0] sample_out;
  logic        rd_en_first, rd_en_second, bypass_second, slot_last, busy, overrun;
  logic [6:0]  index_first, index_second;
  int tot = 0, pass = 0;

  ddc_channel_sequencer #(.N_CH_MAX(128), .SECOND_DELAY(4)) dut (
    .dev_clk(dev_clk), .dev_aresetn(dev_aresetn), .data_in(data_in), .valid_in(valid_in),
    .cfg_n_ch(cfg_n_ch), .cfg_bypass_second(cfg_bypass_second), .cfg_update(cfg_update),
    .clr_overrun(clr_overrun), .sample_out(sample_out), .rd_en_first(rd_en_first),
    .index_first(index_first), .rd_en_second(rd_en_second), .index_second(index_second),
    .bypass_second(bypass_second), .slot_last(slot_last), .busy(busy), .overrun(overrun)
  );

  always #5 dev_clk = ~dev_clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic v; logic [31:0] d; logic [7:0] n; logic b; logic u; logic c;
    logic rd1; logic [6:0] i1; logic l; logic rd2; logic [6:0] i2;
    logic bz; logic by; logic ov; logic [31:0] so;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic v, input logic [31:0] d, input logic [7:0] n, input logic b,
                     input logic u, input logic c, input logic rd1, input logic [6:0] i1,
                     input logic l, input logic rd2, input logic [6:0] i2, input logic bz,
                     input logic by, input logic ov, input logic [31:0] so);
    tbl.push_back('{v, d, n, b, u, c, rd1, i1, l, rd2, i2, bz, by, ov, so});
  endtask

  task automatic step;
    @(posedge dev_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else pass++;
  endtask

  task automatic chk_all(input string tag, input logic rd1, input logic [6:0] i1, input logic l,
                         input logic rd2, input logic [6:0] i2, input logic bz, input logic by,
                         input logic ov, input logic [31:0] so);
    chk({tag, ".rd_en_first"}, 32'(rd_en_first), 32'(rd1));
    chk({tag, ".index_first"}, 32'(index_first), 32'(i1));
    chk({tag, ".slot_last"}, 32'(slot_last), 32'(l));
    chk({tag, ".rd_en_second"}, 32'(rd_en_second), 32'(rd2));
    chk({tag, ".index_second"}, 32'(index_second), 32'(i2));
    chk({tag, ".busy"}, 32'(busy), 32'(bz));
    chk({tag, ".bypass_second"}, 32'(bypass_second), 32'(by));
    chk({tag, ".overrun"}, 32'(overrun), 32'(ov));
    chk({tag, ".sample_out"}, sample_out, so);
  endtask

  // full 128-slot burst from IDLE; second stage trails by 4 cycles
  task automatic burst128(input logic [31:0] d, input string tag);
    valid_in = 1'b1;
    data_in  = d;
    step;
    valid_in = 1'b0;
    chk_all({tag, ".start"}, 0, 0, 0, 0, 0, 0, 0, 0, d);
    for (int k = 1; k <= 133; k++) begin
      step;
      chk_all($sformatf("%s.k%0d", tag, k), k <= 128, (k <= 128) ? 7'(k - 1) : 7'd0, k == 128,
              k >= 5 && k <= 132, (k >= 5 && k <= 132) ? 7'(k - 5) : 7'd0, k <= 128, 0, 0, d);
    end
  endtask

  initial begin
    // n_ch=3: reload in IDLE, two samples 2 cycles apart chain with no gap
    add(0, 32'h0,        3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hA5A50001);
    add(1, 32'h11111111, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h11111111);
    add(0, 32'h0,        3, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 32'h11111111);
    add(1, 32'h22222222, 3, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 32'h11111111);
    add(0, 32'h0,        3, 0, 0, 0, 1, 2, 1, 0, 0, 1, 0, 0, 32'h22222222);
    add(0, 32'h0,        3, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 32'h22222222);
    add(0, 32'h0,        3, 0, 0, 0, 1, 1, 0, 1, 0, 1, 0, 0, 32'h22222222);
    add(0, 32'h0,        3, 0, 0, 0, 1, 2, 1, 1, 1, 1, 0, 0, 32'h22222222);
    add(0, 32'h0,        3, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 32'h22222222);
    add(0, 32'h0,        3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h22222222);
    add(0, 32'h0,        3, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 32'h22222222);
    add(0, 32'h0,        3, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 32'h22222222);
    add(0, 32'h0,        3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h22222222);
    // three back-to-back samples: third dropped; later set beats clr_overrun
    add(1, 32'h33333333, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h33333333);
    add(1, 32'h44444444, 3, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 32'h33333333);
    add(1, 32'h55555555, 3, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 1, 32'h33333333);
    add(0, 32'h0,        3, 0, 0, 0, 1, 2, 1, 0, 0, 1, 0, 1, 32'h44444444);
    add(0, 32'h0,        3, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 32'h44444444);
    add(0, 32'h0,        3, 0, 0, 0, 1, 1, 0, 1, 0, 1, 0, 1, 32'h44444444);
    add(0, 32'h0,        3, 0, 0, 0, 1, 2, 1, 1, 1, 1, 0, 1, 32'h44444444);
    add(0, 32'h0,        3, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 1, 32'h44444444);
    add(1, 32'h66666666, 3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h66666666);
    add(1, 32'h77777777, 3, 0, 0, 0, 1, 0, 0, 1, 1, 1, 0, 1, 32'h66666666);
    add(1, 32'h88888888, 3, 0, 0, 1, 1, 1, 0, 1, 2, 1, 0, 1, 32'h66666666);
    add(0, 32'h0,        3, 0, 0, 1, 1, 2, 1, 0, 0, 1, 0, 0, 32'h77777777);
    add(0, 32'h0,        3, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 32'h77777777);
    add(0, 32'h0,        3, 0, 0, 0, 1, 1, 0, 1, 0, 1, 0, 0, 32'h77777777);
    add(0, 32'h0,        3, 0, 0, 0, 1, 2, 1, 1, 1, 1, 0, 0, 32'h77777777);
    add(0, 32'h0,        3, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 32'h77777777);
    add(0, 32'h0,        3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h77777777);
    add(0, 32'h0,        3, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 32'h77777777);
    add(0, 32'h0,        3, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 32'h77777777);
    add(0, 32'h0,        3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h77777777);
    // bypass requested mid-burst takes effect on the next burst only
    add(1, 32'h99999999, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h99999999);
    add(0, 32'h0,        3, 1, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 32'h99999999);
    add(1, 32'hAAAAAAAA, 3, 1, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 32'h99999999);
    add(0, 32'h0,        3, 1, 0, 0, 1, 2, 1, 0, 0, 1, 1, 0, 32'hAAAAAAAA);
    add(0, 32'h0,        3, 1, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 32'hAAAAAAAA);
    add(0, 32'h0,        3, 1, 0, 0, 1, 1, 0, 1, 0, 1, 1, 0, 32'hAAAAAAAA);
    add(0, 32'h0,        3, 1, 0, 0, 1, 2, 1, 1, 1, 1, 1, 0, 32'hAAAAAAAA);
    add(0, 32'h0,        3, 1, 0, 0, 0, 0, 0, 1, 2, 0, 1, 0, 32'hAAAAAAAA);
    add(0, 32'h0,        3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hAAAAAAAA);
    add(0, 32'h0,        3, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 32'hAAAAAAAA);
    add(0, 32'h0,        3, 1, 0, 0, 0, 0, 0, 0, 2, 0, 1, 0, 32'hAAAAAAAA);
    add(0, 32'h0,        3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hAAAAAAAA);
    add(0, 32'h0,        3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hAAAAAAAA);
    // n_ch=0 clamps to 1: single-slot burst; then 200 clamps to 128
    add(0, 32'h0,        0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hAAAAAAAA);
    add(1, 32'hBBBBBBBB, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hBBBBBBBB);
    add(0, 32'h0,        0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0, 32'hBBBBBBBB);
    add(0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hBBBBBBBB);
    add(0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hBBBBBBBB);
    add(0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hBBBBBBBB);
    add(0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'hBBBBBBBB);
    add(0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hBBBBBBBB);
    add(0, 32'h0,      200, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hBBBBBBBB);

    #1;
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    repeat (2) @(posedge dev_clk);
    #3 dev_aresetn = 1'b1;
    burst128(32'hA5A50001, "full");
    for (int j = 0; j < tbl.size(); j++) begin
      valid_in = tbl[j].v; data_in = tbl[j].d; cfg_n_ch = tbl[j].n;
      cfg_bypass_second = tbl[j].b; cfg_update = tbl[j].u; clr_overrun = tbl[j].c;
      step;
      chk_all($sformatf("vec%0d", j), tbl[j].rd1, tbl[j].i1, tbl[j].l, tbl[j].rd2, tbl[j].i2,
              tbl[j].bz, tbl[j].by, tbl[j].ov, tbl[j].so);
    end
    valid_in = 1'b0; cfg_update = 1'b0; clr_overrun = 1'b0; data_in = '0;
    burst128(32'hCCCCCCCC, "clamp128");
    // asynchronous reset in the middle of a burst
    valid_in = 1'b1;
    data_in  = 32'hDDDDDDDD;
    step;
    valid_in = 1'b0;
    repeat (51) step;
    chk("pre_rst.index_first", 32'(index_first), 32'd50);
    chk("pre_rst.index_second", 32'(index_second), 32'd46);
    #2 dev_aresetn = 1'b0;
    #1 chk_all("async_rst", 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    @(posedge dev_clk);
    #3 dev_aresetn = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step;
      chk_all($sformatf("post_rst%0d", k), 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    end
    valid_in = 1'b1;
    data_in  = 32'hEEEEEEEE;
    step;
    valid_in = 1'b0;
    step;
    chk_all("restart", 1, 0, 0, 0, 0, 1, 0, 0, 32'hEEEEEEEE);
    $display("%0d/%0d checks passed", pass, tot);
    $finish;
  end
endmodule
